// File: rtl/vliw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : vliw_pkg                                                        |
// | Brief    : Shared types and field helpers for the 4-slot VLIW scoreboard.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vliw_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int NUM_REGS  = 32;
   localparam int REG_AW    = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      SLOT_LSU    = 2'd0,
      SLOT_IXU1   = 2'd1,
      SLOT_IXU2   = 2'd2,
      SLOT_BRANCH = 2'd3
   } slot_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } sb_state_e;

   typedef enum logic [1:0] {
      ERR_NONE           = 2'd0,
      ERR_BUNDLE_WAW     = 2'd1,
      ERR_SPURIOUS_WB    = 2'd2,
      ERR_OWNER_MISMATCH = 2'd3
   } sb_err_e;

   function automatic logic [REG_AW-1:0] slot_reg(input logic [NUM_SLOTS*REG_AW-1:0] vec,
                                                  input int s);
      return vec[s*REG_AW +: REG_AW];
   endfunction

   // Source operand k (0 = rs1, 1 = rs2) of slot s.
   function automatic logic [REG_AW-1:0] rs_reg(input logic [NUM_SLOTS*2*REG_AW-1:0] vec,
                                                input int s, input int k);
      return vec[(2*s+k)*REG_AW +: REG_AW];
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: regfile_scoreboard_if                                           |
// | Brief    : Bundle issue handshake and per-slot writeback bus.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface regfile_scoreboard_if import vliw_pkg::*; ();

   logic                             bundle_valid;
   logic                             bundle_ready;
   logic [NUM_SLOTS-1:0]             bundle_rd_we;
   logic [NUM_SLOTS*REG_AW-1:0]      bundle_rd;
   logic [NUM_SLOTS*2-1:0]           bundle_rs_en;
   logic [NUM_SLOTS*2*REG_AW-1:0]    bundle_rs;
   logic                             issue_fire;
   logic [NUM_SLOTS-1:0]             wb_en;
   logic [NUM_SLOTS*REG_AW-1:0]      wb_rd;

   modport master (
      output bundle_valid, bundle_rd_we, bundle_rd, bundle_rs_en, bundle_rs, wb_en, wb_rd,
      input  bundle_ready, issue_fire
   );

   modport slave (
      input  bundle_valid, bundle_rd_we, bundle_rd, bundle_rs_en, bundle_rs, wb_en, wb_rd,
      output bundle_ready, issue_fire
   );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard_hazard_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_hazard_check                                            |
// | Brief    : Combinational RAW/WAW check of a bundle against pending regs.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module regfile_hazard_check import vliw_pkg::*; #(
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [NUM_REGS-1:0]          pending,
   input  logic [NUM_SLOTS-1:0]         rd_we,
   input  logic [NUM_SLOTS*REG_AW-1:0]  rd,
   input  logic [NUM_SLOTS*2-1:0]       rs_en,
   input  logic [NUM_SLOTS*2*REG_AW-1:0] rs,
   output logic                         raw_hz,
   output logic                         waw_hz,
   output logic                         bundle_waw
);

   // Reads compare only against pre-bundle pending state, so a slot reading
   // a register written elsewhere in the same bundle is never a hazard.
   always_comb begin
      raw_hz     = 1'b0;
      waw_hz     = 1'b0;
      bundle_waw = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         for (int k = 0; k < 2; k++) begin
            if (rs_en[2*s+k] && pending[rs_reg(rs, s, k)]) raw_hz = 1'b1;
         end
         if (rd_we[s] && pending[slot_reg(rd, s)]) waw_hz = 1'b1;
         for (int t = s + 1; t < NUM_SLOTS; t++) begin
            if (rd_we[s] && rd_we[t] && (slot_reg(rd, s) == slot_reg(rd, t)) &&
                !(ZERO_REG && (slot_reg(rd, s) == '0)))
               bundle_waw = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_scoreboard                                              |
// | Brief    : Issue-side scoreboard: pending/owner tracking, FSM, errors.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module regfile_scoreboard import vliw_pkg::*; #(
   parameter bit ZERO_REG = 1'b1,
   parameter int CNT_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_scoreboard_if.slave  bus,
   input  logic                 drain_req,
   output logic                 drain_ack,
   output logic [NUM_REGS-1:0]  pending,
   output logic                 idle,
   output logic                 err,
   output logic [1:0]           err_code,
   input  logic                 err_clr,
   output logic [CNT_W-1:0]     stall_cnt
);

   sb_state_e            r_state;
   logic                 r_armed;
   logic [NUM_REGS-1:0]  r_pending;
   slot_e                r_owner [NUM_REGS];
   logic                 r_err;
   sb_err_e              r_err_code;
   logic [CNT_W-1:0]     r_stall_cnt;

   logic                 w_raw_hz;
   logic                 w_waw_hz;
   logic                 w_bundle_waw;
   logic                 w_ready;
   logic                 w_fire;
   logic                 w_bundle_err;
   logic                 w_spurious;
   logic                 w_owner_mm;
   logic [NUM_REGS-1:0]  w_set;
   logic [NUM_REGS-1:0]  w_clr;
   sb_err_e              w_new_err;

   regfile_hazard_check #(.ZERO_REG(ZERO_REG)) u_hazard (
      .pending    (r_pending),
      .rd_we      (bus.bundle_rd_we),
      .rd         (bus.bundle_rd),
      .rs_en      (bus.bundle_rs_en),
      .rs         (bus.bundle_rs),
      .raw_hz     (w_raw_hz),
      .waw_hz     (w_waw_hz),
      .bundle_waw (w_bundle_waw)
   );

   // r_armed is low during reset and the first cycle after it, which masks
   // stale writebacks still in flight from before the reset.
   assign w_ready      = r_armed && (r_state == ST_RUN) && !w_raw_hz && !w_waw_hz && !w_bundle_waw;
   assign w_fire       = bus.bundle_valid && w_ready;
   assign w_bundle_err = r_armed && bus.bundle_valid && (r_state == ST_RUN) && w_bundle_waw;

   always_comb begin
      w_set      = '0;
      w_clr      = '0;
      w_spurious = 1'b0;
      w_owner_mm = 1'b0;
      if (r_armed) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (bus.wb_en[s] && !(ZERO_REG && (slot_reg(bus.wb_rd, s) == '0))) begin
               if (!r_pending[slot_reg(bus.wb_rd, s)]) begin
                  w_spurious = 1'b1;
               end else begin
                  w_clr[slot_reg(bus.wb_rd, s)] = 1'b1;
                  if (r_owner[slot_reg(bus.wb_rd, s)] != slot_e'(s)) w_owner_mm = 1'b1;
               end
            end
            if (w_fire && bus.bundle_rd_we[s] && !(ZERO_REG && (slot_reg(bus.bundle_rd, s) == '0)))
               w_set[slot_reg(bus.bundle_rd, s)] = 1'b1;
         end
      end
   end

   always_comb begin
      w_new_err = ERR_NONE;
      if (w_bundle_err)    w_new_err = ERR_BUNDLE_WAW;
      else if (w_spurious) w_new_err = ERR_SPURIOUS_WB;
      else if (w_owner_mm) w_new_err = ERR_OWNER_MISMATCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_armed     <= 1'b0;
         r_pending   <= '0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_stall_cnt <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_owner[i] <= SLOT_LSU;
      end else begin
         r_armed   <= 1'b1;
         // Set after clear: a new issue wins over an erroneous same-cycle wb.
         r_pending <= (r_pending & ~w_clr) | w_set;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (w_fire && bus.bundle_rd_we[s])
               r_owner[slot_reg(bus.bundle_rd, s)] <= slot_e'(s);
         end

         if ((r_state == ST_RUN) && bus.bundle_valid && !w_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);

         if (!err_clr && (w_new_err != ERR_NONE)) begin
            r_state <= ST_HALT;
            if (!r_err) begin
               r_err      <= 1'b1;
               r_err_code <= w_new_err;
            end
         end else begin
            if (err_clr) begin
               r_err      <= 1'b0;
               r_err_code <= ERR_NONE;
            end
            unique case (r_state)
               ST_RUN:   if (drain_req)  r_state <= ST_DRAIN;
               ST_DRAIN: if (!drain_req) r_state <= ST_RUN;
               ST_HALT:  if (err_clr)    r_state <= ST_RUN;
               default:                  r_state <= ST_RUN;
            endcase
         end
      end
   end

   assign bus.bundle_ready = w_ready;
   assign bus.issue_fire   = w_fire;
   assign pending          = r_pending;
   assign idle             = (r_pending == '0);
   assign drain_ack        = (r_state == ST_DRAIN) && (r_pending == '0);
   assign err              = r_err;
   assign err_code         = r_err_code;
   assign stall_cnt        = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_scoreboard                                           |
// | Brief    : Directed table-driven and sequence checks of the scoreboard.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_regfile_scoreboard;
   import vliw_pkg::*;

   localparam int AW = REG_AW;

   typedef struct packed {
      logic                   valid;
      logic [3:0]             rd_we;
      logic [4*AW-1:0]        rd;
      logic [7:0]             rs_en;
      logic [8*AW-1:0]        rs;
      logic [3:0]             wb_en;
      logic [4*AW-1:0]        wb_rd;
      logic                   exp_ready;
      logic                   exp_fire;
      logic [31:0]            exp_pend;
      logic [31:0]            exp_stall;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        drain_req;
   logic        drain_ack;
   logic [31:0] pending;
   logic        idle;
   logic        err;
   logic [1:0]  err_code;
   logic        err_clr;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   regfile_scoreboard_if sb_if ();

   regfile_scoreboard #(.ZERO_REG(1'b1), .CNT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (sb_if),
      .drain_req (drain_req),
      .drain_ack (drain_ack),
      .pending   (pending),
      .idle      (idle),
      .err       (err),
      .err_code  (err_code),
      .err_clr   (err_clr),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [4*AW-1:0] f_rd(input int s, input int r);
      logic [4*AW-1:0] v;
      v = '0;
      v[s*AW +: AW] = AW'(r);
      return v;
   endfunction

   function automatic logic [8*AW-1:0] f_rs(input int s, input int k, input int r);
      logic [8*AW-1:0] v;
      v = '0;
      v[(2*s+k)*AW +: AW] = AW'(r);
      return v;
   endfunction

   function automatic logic [31:0] p(input int r);
      return 32'd1 << r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic bundle(input logic v, input logic [3:0] we, input logic [4*AW-1:0] rd,
                         input logic [7:0] rse, input logic [8*AW-1:0] rs);
      sb_if.bundle_valid = v;
      sb_if.bundle_rd_we = we;
      sb_if.bundle_rd    = rd;
      sb_if.bundle_rs_en = rse;
      sb_if.bundle_rs    = rs;
   endtask

   task automatic wb(input logic [3:0] en, input logic [4*AW-1:0] rd);
      sb_if.wb_en = en;
      sb_if.wb_rd = rd;
   endtask

   task automatic quiet();
      bundle(1'b0, '0, '0, '0, '0);
      wb('0, '0);
      err_clr = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input logic [3:0] we, input logic [4*AW-1:0] rd,
                      input logic [7:0] rse, input logic [8*AW-1:0] rs,
                      input logic [3:0] wbe, input logic [4*AW-1:0] wbr,
                      input logic er, input logic ef, input logic [31:0] ep, input int es);
      vecs.push_back('{v, we, rd, rse, rs, wbe, wbr, er, ef, ep, 32'(es)});
   endtask

   initial begin
      logic [4*AW-1:0] rd124;
      rd124 = f_rd(0, 1) | f_rd(1, 2) | f_rd(2, 4);

      // RAW stall and release on writeback
      add(1, 4'b0001, f_rd(0, 5), 8'h00, '0, 4'b0000, '0, 1, 1, 0, 0);
      add(1, 4'b0000, '0, 8'h04, f_rs(1, 0, 5), 4'b0000, '0, 0, 0, p(5), 0);
      add(1, 4'b0000, '0, 8'h04, f_rs(1, 0, 5), 4'b0000, '0, 0, 0, p(5), 1);
      add(1, 4'b0000, '0, 8'h04, f_rs(1, 0, 5), 4'b0001, f_rd(0, 5), 0, 0, p(5), 2);
      add(1, 4'b0000, '0, 8'h04, f_rs(1, 0, 5), 4'b0000, '0, 1, 1, 0, 3);
      // intra-bundle read of a written register
      add(1, 4'b0010, f_rd(1, 3), 8'h40, f_rs(3, 0, 3), 4'b0000, '0, 1, 1, 0, 3);
      add(0, 4'b0000, '0, 8'h00, '0, 4'b0000, '0, 1, 0, p(3), 3);
      // register 0 never becomes pending
      add(1, 4'b0001, f_rd(0, 0), 8'h00, '0, 4'b0000, '0, 1, 1, p(3), 3);
      add(1, 4'b0001, f_rd(0, 0), 8'h10, f_rs(2, 0, 0), 4'b0010, f_rd(1, 3), 1, 1, p(3), 3);
      add(1, 4'b0001, f_rd(0, 0), 8'h00, '0, 4'b0000, '0, 1, 1, 0, 3);
      // WAW across bundles
      add(1, 4'b0100, f_rd(2, 12), 8'h00, '0, 4'b0000, '0, 1, 1, 0, 3);
      add(1, 4'b1000, f_rd(3, 12), 8'h00, '0, 4'b0000, '0, 0, 0, p(12), 3);
      add(1, 4'b1000, f_rd(3, 12), 8'h00, '0, 4'b0100, f_rd(2, 12), 0, 0, p(12), 4);
      add(1, 4'b1000, f_rd(3, 12), 8'h00, '0, 4'b0000, '0, 1, 1, 0, 5);
      // three-slot issue, rs2 RAW, multi-slot writeback
      add(1, 4'b0111, rd124, 8'hC0, f_rs(3, 0, 1) | f_rs(3, 1, 2), 4'b1000, f_rd(3, 12), 1, 1, p(12), 5);
      add(1, 4'b0000, '0, 8'h08, f_rs(1, 1, 4), 4'b0111, rd124, 0, 0, p(1) | p(2) | p(4), 5);
      add(0, 4'b0000, '0, 8'h00, '0, 4'b0000, '0, 1, 0, 0, 6);

      // reset state
      quiet();
      drain_req = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      bundle(1'b1, 4'b0001, f_rd(0, 5), '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(sb_if.bundle_ready), 0);
      chk("rst_fire", 32'(sb_if.issue_fire), 0);
      chk("rst_pending", pending, 0);
      chk("rst_err", {29'd0, err, err_code}, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_ack_idle", {30'd0, drain_ack, idle}, 32'd1);
      quiet();
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         next_cycle();
         bundle(vecs[i].valid, vecs[i].rd_we, vecs[i].rd, vecs[i].rs_en, vecs[i].rs);
         wb(vecs[i].wb_en, vecs[i].wb_rd);
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), 32'(sb_if.bundle_ready), 32'(vecs[i].exp_ready));
         chk($sformatf("v%0d_fire", i), 32'(sb_if.issue_fire), 32'(vecs[i].exp_fire));
         chk($sformatf("v%0d_pending", i), pending, vecs[i].exp_pend);
         chk($sformatf("v%0d_stall", i), stall_cnt, vecs[i].exp_stall);
      end
      chk("tbl_err", {29'd0, err, err_code}, 0);

      // bundle-internal WAW -> HALT, then err_clr
      next_cycle(); quiet(); bundle(1'b1, 4'b0110, f_rd(1, 7) | f_rd(2, 7), '0, '0);
      @(negedge clk);
      chk("bwaw_ready", 32'(sb_if.bundle_ready), 0);
      chk("bwaw_fire", 32'(sb_if.issue_fire), 0);
      next_cycle(); bundle(1'b1, 4'b0001, f_rd(0, 8), '0, '0);
      @(negedge clk);
      chk("bwaw_err", {30'd0, err, 1'b0}, 32'd2);
      chk("bwaw_code", 32'(err_code), 32'(ERR_BUNDLE_WAW));
      chk("halt_ready", 32'(sb_if.bundle_ready), 0);
      chk("bwaw_pending", pending, 0);
      next_cycle(); quiet(); err_clr = 1'b1;
      @(negedge clk);
      chk("halt_stall", stall_cnt, 7);
      next_cycle(); quiet(); bundle(1'b0, 4'b0001, f_rd(0, 8), '0, '0);
      @(negedge clk);
      chk("clr_err", {29'd0, err, err_code}, 0);
      chk("clr_ready", 32'(sb_if.bundle_ready), 1);

      // spurious writeback, then owner mismatch
      next_cycle(); quiet(); wb(4'b0100, f_rd(2, 9));
      next_cycle(); quiet();
      @(negedge clk);
      chk("spur_code", {29'd0, err, err_code}, {29'd0, 1'b1, ERR_SPURIOUS_WB});
      next_cycle(); err_clr = 1'b1;
      next_cycle(); quiet(); bundle(1'b1, 4'b0010, f_rd(1, 9), '0, '0);
      @(negedge clk);
      chk("own_issue", 32'(sb_if.issue_fire), 1);
      next_cycle(); quiet(); wb(4'b0001, f_rd(0, 9));
      @(negedge clk);
      chk("own_pend_before", pending, p(9));
      next_cycle(); quiet(); err_clr = 1'b1; wb(4'b0100, f_rd(2, 10));
      @(negedge clk);
      chk("own_code", {29'd0, err, err_code}, {29'd0, 1'b1, ERR_OWNER_MISMATCH});
      chk("own_pend_after", pending, 0);
      next_cycle(); quiet();
      @(negedge clk);
      chk("clr_beats_err", {29'd0, err, err_code}, 0);
      chk("clr_beats_ready", 32'(sb_if.bundle_ready), 1);

      // two errors in one cycle: lowest code recorded
      next_cycle(); quiet();
      bundle(1'b1, 4'b0110, f_rd(1, 7) | f_rd(2, 7), '0, '0); wb(4'b0001, f_rd(0, 11));
      next_cycle(); quiet();
      @(negedge clk);
      chk("prio_code", {29'd0, err, err_code}, {29'd0, 1'b1, ERR_BUNDLE_WAW});
      next_cycle(); err_clr = 1'b1;
      next_cycle(); quiet();

      // drain with three pending registers
      next_cycle(); bundle(1'b1, 4'b0111, rd124, '0, '0);
      next_cycle(); quiet(); drain_req = 1'b1;
      @(negedge clk);
      chk("drn_pend", pending, p(1) | p(2) | p(4));
      chk("drn_ack0", 32'(drain_ack), 0);
      next_cycle(); bundle(1'b1, 4'b0001, f_rd(0, 8), '0, '0); wb(4'b0001, f_rd(0, 1));
      @(negedge clk);
      chk("drn_ready", 32'(sb_if.bundle_ready), 0);
      chk("drn_ack1", 32'(drain_ack), 0);
      chk("drn_stall", stall_cnt, 8);
      next_cycle(); wb(4'b0010, f_rd(1, 2));
      @(negedge clk);
      chk("drn_ack2", 32'(drain_ack), 0);
      next_cycle(); quiet(); wb(4'b0100, f_rd(2, 4));
      @(negedge clk);
      chk("drn_ack3", 32'(drain_ack), 0);
      next_cycle(); quiet();
      @(negedge clk);
      chk("drn_ack_done", {30'd0, drain_ack, idle}, 32'd3);
      chk("drn_ready_done", 32'(sb_if.bundle_ready), 0);
      next_cycle(); drain_req = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("drn_exit", {30'd0, drain_ack, sb_if.bundle_ready}, 32'd1);

      // reset in the middle of a drain
      next_cycle(); bundle(1'b1, 4'b0001, f_rd(0, 6), '0, '0);
      next_cycle(); quiet(); drain_req = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("mid_pend", pending, p(6));
      chk("mid_ready", 32'(sb_if.bundle_ready), 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pend", pending, 0);
      chk("mid_rst_stall", stall_cnt, 0);
      next_cycle(); rst_n = 1'b1; drain_req = 1'b0; wb(4'b0001, f_rd(0, 6));
      @(negedge clk);
      chk("mask_ready", 32'(sb_if.bundle_ready), 0);
      next_cycle(); quiet();
      @(negedge clk);
      chk("mask_err", {29'd0, err, err_code}, 0);
      chk("post_rst_run", {30'd0, drain_ack, sb_if.bundle_ready}, 32'd1);
      chk("post_rst_pend", pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
